// File: rtl/cnn_argmax_stream.sv
// cnn_argmax_stream: streaming top-2 argmax over one frame of signed logits with a registered, held result
module cnn_argmax_stream #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W = 40,
  parameter int IDX_W = $clog2(NUM_CLASSES),
  parameter logic [DATA_W:0] CONF_THRESH = '0,
  parameter int FRAME_CNT_W = 16
)(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clr,
  input  logic                   logit_valid,
  output logic                   logit_ready,
  input  logic [DATA_W-1:0]      logit_data,
  input  logic                   logit_last,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [IDX_W-1:0]       res_idx,
  output logic [DATA_W-1:0]      res_max,
  output logic [DATA_W:0]        res_margin,
  output logic                   res_lowconf,
  output logic                   res_err,
  output logic [FRAME_CNT_W-1:0] res_frame
);
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t state, state_nxt;
  logic [IDX_W-1:0] cnt, best_idx, nxt_idx;
  logic signed [DATA_W-1:0] din, best, second, nxt_best, nxt_sec;
  logic sec_v, nxt_sec_v, fire, at_end, frame_end;
  logic [DATA_W:0] margin;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  assign din = logit_data;
  assign logit_ready = state == COLLECT;
  assign res_valid = state == HOLD;
  assign fire = logit_valid && logit_ready && !clr;
  assign at_end = cnt == IDX_W'(NUM_CLASSES - 1);
  assign frame_end = fire && (logit_last || at_end);
  assign margin = nxt_sec_v ? {nxt_best[DATA_W-1], nxt_best} - {nxt_sec[DATA_W-1], nxt_sec} : '0;
  // top-2 tracker including the beat currently presented; strict compare keeps the lowest index on ties
  always_comb begin
    nxt_best = best;
    nxt_idx = best_idx;
    nxt_sec = second;
    nxt_sec_v = sec_v;
    if (cnt == '0) begin
      nxt_best = din;
      nxt_idx = '0;
      nxt_sec_v = 1'b0;
    end else if (din > best) begin
      nxt_sec = best;
      nxt_sec_v = 1'b1;
      nxt_best = din;
      nxt_idx = cnt;
    end else if (!sec_v || din > second) begin
      nxt_sec = din;
      nxt_sec_v = 1'b1;
    end
  end
  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= COLLECT;
    else state <= state_nxt;
  end
  // collect until frame end, hold the result until it is taken; clr aborts either phase
  always_comb begin
    state_nxt = state;
    if (clr) state_nxt = COLLECT;
    else if (state == COLLECT && frame_end) state_nxt = HOLD;
    else if (state == HOLD && res_ready) state_nxt = COLLECT;
  end
  // running scores, beat counter and the registered per-frame result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      best <= '0;
      best_idx <= '0;
      second <= '0;
      sec_v <= 1'b0;
      frame_cnt <= '0;
      res_idx <= '0;
      res_max <= '0;
      res_margin <= '0;
      res_lowconf <= 1'b0;
      res_err <= 1'b0;
      res_frame <= '0;
    end else if (clr) begin
      cnt <= '0;
      sec_v <= 1'b0;
    end else begin
      if (fire) begin
        best <= nxt_best;
        best_idx <= nxt_idx;
        second <= nxt_sec;
        sec_v <= nxt_sec_v;
        cnt <= frame_end ? '0 : cnt + 1'b1;
      end
      if (frame_end) begin
        res_idx <= nxt_idx;
        res_max <= nxt_best;
        res_margin <= margin;
        res_lowconf <= !nxt_sec_v || margin < CONF_THRESH;
        res_err <= !(logit_last && at_end);
        res_frame <= frame_cnt;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cnn_argmax_stream.sv
// tb_cnn_argmax_stream: directed frames with hand-computed top-2 results
module tb_cnn_argmax_stream;
  logic clk = 0, rstn = 0, clr = 0, logit_valid = 0, logit_last = 0, res_ready = 1;
  logic [39:0] logit_data = '0;
  logic logit_ready, res_valid, res_lowconf, res_err;
  logic [3:0] res_idx;
  logic [39:0] res_max;
  logic [40:0] res_margin;
  logic [15:0] res_frame;
  logic [39:0] v [10];
  logic pre_valid;
  int checks = 0, errors = 0;

  cnn_argmax_stream #(.NUM_CLASSES(10), .DATA_W(40), .CONF_THRESH(41'd1), .FRAME_CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .logit_valid(logit_valid), .logit_ready(logit_ready),
    .logit_data(logit_data), .logit_last(logit_last), .res_valid(res_valid), .res_ready(res_ready),
    .res_idx(res_idx), .res_max(res_max), .res_margin(res_margin), .res_lowconf(res_lowconf),
    .res_err(res_err), .res_frame(res_frame));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [39:0] d, input logic l);
    int n = 0;
    logit_valid = 1;
    logit_data = d;
    logit_last = l;
    while (!logit_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!logit_ready) chk("ready_timeout", 0, 1);
    pre_valid = res_valid;
    @(posedge clk); #1;
    logit_valid = 0;
    logit_last = 0;
  endtask

  task automatic frame(input int n, input bit wl);
    for (int i = 0; i < n; i++) send(v[i], wl && i == n - 1);
  endtask

  task automatic expect_res(input string tag, input logic [3:0] idx, input logic [39:0] mx,
                            input logic [40:0] mg, input logic lc, input logic er, input logic [15:0] fr);
    chk({tag, "_pre_valid"}, pre_valid, 0);
    chk({tag, "_valid"}, res_valid, 1);
    chk({tag, "_idx"}, res_idx, idx);
    chk({tag, "_max"}, res_max, mx);
    chk({tag, "_margin"}, res_margin, mg);
    chk({tag, "_lowconf"}, res_lowconf, lc);
    chk({tag, "_err"}, res_err, er);
    chk({tag, "_frame"}, res_frame, fr);
  endtask

  initial begin
    logic hold_ok;
    logic [3:0] h_idx;
    logic [39:0] h_max;
    #12;
    chk("rst_valid", res_valid, 0);
    chk("rst_idx", res_idx, 0);
    chk("rst_max", res_max, 0);
    chk("rst_margin", res_margin, 0);
    chk("rst_frame", res_frame, 0);
    @(posedge clk); #1;
    rstn = 1;
    chk("rst_ready", logit_ready, 1);

    v = '{40'd5, -40'sd3, 40'd9, 40'd2, 40'd9, 40'd0, 40'd1, -40'sd7, 40'd4, 40'd8};
    frame(10, 1);
    expect_res("t1", 2, 9, 0, 1, 0, 0);
    chk("t1_hold_ready", logit_ready, 0);
    @(posedge clk); #1;
    chk("t1_drop_valid", res_valid, 0);

    res_ready = 0;
    frame(10, 1);
    expect_res("t2", 2, 9, 0, 1, 0, 1);
    hold_ok = 1;
    h_idx = res_idx;
    h_max = res_max;
    repeat (5) begin
      @(posedge clk); #1;
      if (!res_valid || logit_ready || res_idx != h_idx || res_max != h_max || res_frame != 16'd1) hold_ok = 0;
    end
    chk("t2_hold_stable", hold_ok, 1);
    res_ready = 1;
    @(posedge clk); #1;
    chk("t2_release_valid", res_valid, 0);
    chk("t2_release_ready", logit_ready, 1);

    for (int i = 0; i < 10; i++) v[i] = 40'h80_0000_0000;
    frame(10, 1);
    expect_res("t3min", 0, 40'h80_0000_0000, 0, 1, 0, 2);
    for (int i = 0; i < 10; i++) v[i] = 40'(i);
    frame(10, 1);
    expect_res("t3inc", 9, 9, 1, 0, 0, 3);

    v[0] = 1; v[1] = 7; v[2] = 3; v[3] = 2;
    frame(4, 1);
    expect_res("t4short", 1, 7, 4, 0, 1, 4);
    v = '{40'd5, -40'sd3, 40'd9, 40'd2, 40'd9, 40'd0, 40'd1, -40'sd7, 40'd4, 40'd8};
    frame(10, 1);
    expect_res("t4full", 2, 9, 0, 1, 0, 5);

    v = '{40'd3, 40'd1, 40'd4, 40'd1, 40'd5, 40'd9, 40'd2, 40'd6, 40'd5, 40'd3};
    frame(10, 0);
    expect_res("t5nolast", 5, 9, 3, 0, 1, 6);
    v[0] = 42;
    frame(1, 1);
    expect_res("t5one", 0, 42, 0, 1, 1, 7);

    for (int i = 0; i < 5; i++) send(40'd100 + 40'(i), 0);
    logit_valid = 1;
    logit_data = 40'd1000;
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    logit_valid = 0;
    chk("t6_clr_valid", res_valid, 0);
    for (int i = 0; i < 10; i++) v[i] = 40'(i);
    frame(10, 1);
    expect_res("t6clr", 9, 9, 1, 0, 0, 8);
    @(posedge clk); #1;
    chk("t6_single_result", res_valid, 0);

    res_ready = 0;
    frame(10, 1);
    expect_res("t6hold", 9, 9, 1, 0, 0, 9);
    @(posedge clk); #1;
    rstn = 0;
    #1;
    chk("t6_rst_valid", res_valid, 0);
    chk("t6_rst_frame", res_frame, 0);
    chk("t6_rst_idx", res_idx, 0);
    @(posedge clk); #1;
    rstn = 1;
    res_ready = 1;
    chk("t6_rst_ready", logit_ready, 1);
    frame(10, 1);
    expect_res("t6after", 9, 9, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
